// File: rtl/tube_pkg.sv
// Shared constants for the 7-segment tube write path: register addresses and arbiter FSM encoding.
package tube_pkg;

  localparam logic [2:0] TUBE_ADDR_LO = 3'b110;
  localparam logic [2:0] TUBE_ADDR_HI = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  function automatic logic tube_addr_valid(input logic [2:0] addr);
    return (addr == TUBE_ADDR_LO) || (addr == TUBE_ADDR_HI);
  endfunction

endpackage

// File: rtl/tube_write_arbiter_if.sv
// One requester's write handshake toward the tube arbiter (CPU bridge or debug monitor).
interface tube_write_arbiter_if;
  logic        req;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;

  modport master (output req, addr, wdata, input ack, err);
  modport slave  (input req, addr, wdata, output ack, err);
endinterface

// File: rtl/tube_write_arbiter.sv
// Round-robin arbiter for the tube write port with a minimum-visibility hold after ownership changes.
// state | meaning:  IDLE = waiting for an eligible request;  ISSUE = ack/write pulse on outputs.
module tube_write_arbiter
  import tube_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int HOLD_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  tube_write_arbiter_if.slave  rq0,
  tube_write_arbiter_if.slave  rq1,
  output logic                 tube_we,
  output logic [2:0]           tube_addr,
  output logic [31:0]          tube_din,
  output logic                 owner_valid,
  output logic                 owner
);

  arb_state_e        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        ack_q;
  logic [1:0]        err_q;

  logic        elig0;
  logic        elig1;
  logic        grant_any;
  logic        sel;
  logic [2:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_ok;
  logic        owner_change;

  assign rq0.ack = ack_q[0];
  assign rq0.err = err_q[0];
  assign rq1.ack = ack_q[1];
  assign rq1.err = err_q[1];

  always_comb begin
    elig0        = rq0.req && (!owner_valid || (owner == 1'b0) || (hold_cnt == '0));
    elig1        = rq1.req && (!owner_valid || (owner == 1'b1) || (hold_cnt == '0));
    grant_any    = elig0 || elig1;
    // Both eligible: favour the non-owner; before any write, requester 0 wins.
    if (elig0 && elig1) sel = owner_valid ? ~owner : 1'b0;
    else                sel = elig1;
    sel_addr     = sel ? rq1.addr  : rq0.addr;
    sel_wdata    = sel ? rq1.wdata : rq0.wdata;
    sel_ok       = tube_addr_valid(sel_addr);
    owner_change = sel_ok && (!owner_valid || (sel != owner));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      tube_we     <= 1'b0;
      tube_addr   <= '0;
      tube_din    <= '0;
      owner_valid <= 1'b0;
      owner       <= 1'b0;
    end else begin
      ack_q   <= '0;
      err_q   <= '0;
      tube_we <= 1'b0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state      <= ST_ISSUE;
            ack_q[sel] <= 1'b1;
            if (sel_ok) begin
              tube_we   <= 1'b1;
              tube_addr <= sel_addr;
              tube_din  <= sel_wdata;
              // Same-owner writes leave hold_cnt alone so the owner cannot starve the other side.
              if (owner_change) begin
                owner       <= sel;
                owner_valid <= 1'b1;
                hold_cnt    <= HOLD_W'(HOLD_CYCLES);
              end
            end else begin
              err_q[sel] <= 1'b1;
            end
          end
        end
        ST_ISSUE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tube_write_arbiter.sv
// Directed bench for tube_write_arbiter: hold lockout, round-robin, invalid address and reset cases.
module tb_tube_write_arbiter;
  import tube_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tube_we;
  logic [2:0]  tube_addr;
  logic [31:0] tube_din;
  logic        owner_valid;
  logic        owner;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  tube_write_arbiter_if bus0 ();
  tube_write_arbiter_if bus1 ();

  tube_write_arbiter #(.HOLD_CYCLES(1024), .HOLD_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rq0         (bus0),
    .rq1         (bus1),
    .tube_we     (tube_we),
    .tube_addr   (tube_addr),
    .tube_din    (tube_din),
    .owner_valid (owner_valid),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until the chosen ack is seen (bounded by limit).
  task automatic wait_ack(input int which, input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!((which == 1) ? bus1.ack : bus0.ack) && cnt < limit);
  endtask

  task automatic drive(input int which, input logic r, input logic [2:0] a, input logic [31:0] d);
    if (which == 1) begin
      bus1.req = r; bus1.addr = a; bus1.wdata = d;
    end else begin
      bus0.req = r; bus0.addr = a; bus0.wdata = d;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 3'b000, 32'h0);
    drive(1, 1'b0, 3'b000, 32'h0);
    repeat (3) @(negedge clk);

    chk("rst_tube_we", tube_we, 0);
    chk("rst_tube_addr", tube_addr, 0);
    chk("rst_tube_din", tube_din, 0);
    chk("rst_ack0", bus0.ack, 0);
    chk("rst_err1", bus1.err, 0);
    chk("rst_owner_valid", owner_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_hold", dut.hold_cnt, 0);
    reset = 1'b0;

    // First write from requester 0 takes ownership
    drive(0, 1'b1, TUBE_ADDR_LO, 32'h1234_5678);
    wait_ack(0, 10, n);
    chk("t1_latency", n, 1);
    chk("t1_ack0", bus0.ack, 1);
    chk("t1_err0", bus0.err, 0);
    chk("t1_we", tube_we, 1);
    chk("t1_addr", tube_addr, 3'b110);
    chk("t1_din", tube_din, 32'h1234_5678);
    chk("t1_owner", owner, 0);
    chk("t1_owner_valid", owner_valid, 1);
    chk("t1_hold", dut.hold_cnt, 1024);

    // Requester 1 locked out until the hold drains
    drive(0, 1'b0, TUBE_ADDR_LO, 32'h1234_5678);
    drive(1, 1'b1, TUBE_ADDR_HI, 32'h4);
    @(negedge clk);
    chk("t2_hold_dec", dut.hold_cnt, 1023);
    chk("t2_we_low", tube_we, 0);
    chk("t2_din_held", tube_din, 32'h1234_5678);
    chk("t2_ack0_pulse", bus0.ack, 0);
    wait_ack(1, 2000, n);
    chk("t2_wait", n, 1024);
    chk("t2_we", tube_we, 1);
    chk("t2_addr", tube_addr, 3'b111);
    chk("t2_din", tube_din, 32'h4);
    chk("t2_owner", owner, 1);
    chk("t2_hold", dut.hold_cnt, 1024);

    // Invalid address from the current owner: error, no write, no reload
    drive(1, 1'b0, 3'b000, 32'h0);
    @(negedge clk);
    drive(1, 1'b1, 3'b000, 32'hFFFF_FFFF);
    wait_ack(1, 10, n);
    chk("t4a_latency", n, 1);
    chk("t4a_err1", bus1.err, 1);
    chk("t4a_we", tube_we, 0);
    chk("t4a_din", tube_din, 32'h4);
    chk("t4a_owner", owner, 1);
    chk("t4a_hold", dut.hold_cnt, 1022);

    // Requester 0 regains ownership once the hold expires
    drive(1, 1'b0, 3'b000, 32'h0);
    drive(0, 1'b1, TUBE_ADDR_LO, 32'hAAAA_0000);
    wait_ack(0, 2000, n);
    chk("ta_wait", n, 1023);
    chk("ta_din", tube_din, 32'hAAAA_0000);
    chk("ta_owner", owner, 0);
    chk("ta_hold", dut.hold_cnt, 1024);

    drive(0, 1'b0, TUBE_ADDR_LO, 32'h0);
    repeat (1030) @(negedge clk);
    chk("t3_hold_zero", dut.hold_cnt, 0);

    // Both requesting with hold expired and owner 0: requester 1 wins
    drive(0, 1'b1, TUBE_ADDR_LO, 32'h5);
    drive(1, 1'b1, TUBE_ADDR_HI, 32'h6);
    wait_ack(1, 10, n);
    chk("t3_latency", n, 1);
    chk("t3_ack0_low", bus0.ack, 0);
    chk("t3_din1", tube_din, 32'h6);
    chk("t3_owner1", owner, 1);
    chk("t3_hold1", dut.hold_cnt, 1024);
    drive(1, 1'b0, TUBE_ADDR_HI, 32'h0);
    wait_ack(0, 2000, n);
    chk("t3_wait0", n, 1025);
    chk("t3_din0", tube_din, 32'h5);
    chk("t3_owner0", owner, 0);
    chk("t3_hold0", dut.hold_cnt, 1024);

    // Invalid address from requester 0
    drive(0, 1'b0, TUBE_ADDR_LO, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 3'b000, 32'hDEAD_BEEF);
    wait_ack(0, 10, n);
    chk("t4_latency", n, 1);
    chk("t4_err0", bus0.err, 1);
    chk("t4_we", tube_we, 0);
    chk("t4_din", tube_din, 32'h5);
    chk("t4_owner", owner, 0);
    chk("t4_hold", dut.hold_cnt, 1022);

    // Owner streams three writes while requester 1 waits
    drive(0, 1'b1, TUBE_ADDR_LO, 32'h11);
    drive(1, 1'b1, TUBE_ADDR_HI, 32'h99);
    wait_ack(0, 10, n);
    chk("t5_gap1", n, 2);
    chk("t5_din1", tube_din, 32'h11);
    chk("t5_hold1", dut.hold_cnt, 1020);
    chk("t5_ack1_low", bus1.ack, 0);
    drive(0, 1'b1, TUBE_ADDR_LO, 32'h22);
    wait_ack(0, 10, n);
    chk("t5_gap2", n, 2);
    chk("t5_hold2", dut.hold_cnt, 1018);
    drive(0, 1'b1, TUBE_ADDR_LO, 32'h33);
    wait_ack(0, 10, n);
    chk("t5_gap3", n, 2);
    chk("t5_din3", tube_din, 32'h33);
    chk("t5_hold3", dut.hold_cnt, 1016);
    drive(0, 1'b0, TUBE_ADDR_LO, 32'h0);
    wait_ack(1, 2000, n);
    chk("t5_wait1", n, 1017);
    chk("t5_din_r1", tube_din, 32'h99);
    chk("t5_owner", owner, 1);
    chk("t5_hold_r1", dut.hold_cnt, 1024);

    // Reset during the ISSUE cycle
    drive(1, 1'b0, TUBE_ADDR_HI, 32'h0);
    @(negedge clk);
    drive(1, 1'b1, TUBE_ADDR_HI, 32'h88);
    wait_ack(1, 10, n);
    chk("t6_latency", n, 1);
    chk("t6_we_pre", tube_we, 1);
    reset = 1'b1;
    drive(1, 1'b0, TUBE_ADDR_HI, 32'h0);
    @(negedge clk);
    chk("t6_we", tube_we, 0);
    chk("t6_addr", tube_addr, 0);
    chk("t6_din", tube_din, 0);
    chk("t6_ack1", bus1.ack, 0);
    chk("t6_owner_valid", owner_valid, 0);
    chk("t6_owner", owner, 0);
    chk("t6_hold", dut.hold_cnt, 0);
    chk("t6_state", dut.state, ST_IDLE);
    reset = 1'b0;

    drive(0, 1'b1, TUBE_ADDR_HI, 32'h0F);
    wait_ack(0, 10, n);
    chk("t6_post_latency", n, 1);
    chk("t6_post_addr", tube_addr, 3'b111);
    chk("t6_post_owner_valid", owner_valid, 1);
    drive(0, 1'b0, TUBE_ADDR_HI, 32'h0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
